// File: rtl/host_msg_bridge.sv
// host_msg_bridge: NASTI slave that moves {id,data} host messages through a request and a response FIFO.

// Small power-of-two FIFO with wrap-bit pointers; callers guard push with !full and pop with !empty.
module host_msg_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module host_msg_bridge #(
    parameter int unsigned ID_WIDTH       = 1,
    parameter int unsigned USER_WIDTH     = 1,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned MSG_ID_WIDTH   = 16,
    parameter int unsigned MSG_DATA_WIDTH = 16,
    parameter int unsigned REQ_DEPTH      = 4,
    parameter int unsigned RESP_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    // write address
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [ID_WIDTH-1:0]       aw_id,
    input  logic [7:0]                aw_len,
    input  logic [USER_WIDTH-1:0]     aw_user,
    // write data
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic                      w_last,
    // write response
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic [ID_WIDTH-1:0]       b_id,
    output logic [1:0]                b_resp,
    output logic [USER_WIDTH-1:0]     b_user,
    // read address
    input  logic                      ar_valid,
    output logic                      ar_ready,
    input  logic [ID_WIDTH-1:0]       ar_id,
    input  logic [7:0]                ar_len,
    input  logic [USER_WIDTH-1:0]     ar_user,
    // read data
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [ID_WIDTH-1:0]       r_id,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    output logic [USER_WIDTH-1:0]     r_user,
    // host request port
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [MSG_ID_WIDTH-1:0]   req_id,
    output logic [MSG_DATA_WIDTH-1:0] req_data,
    // host response port
    input  logic                      resp_valid,
    output logic                      resp_ready,
    input  logic [MSG_ID_WIDTH-1:0]   resp_id,
    input  logic [MSG_DATA_WIDTH-1:0] resp_data
);
    localparam int unsigned MSG_W       = MSG_ID_WIDTH + MSG_DATA_WIDTH;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t              w_state, w_state_nx;
    r_state_t              r_state, r_state_nx;

    logic                  w_single_q;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [USER_WIDTH-1:0] w_user_q;
    logic [1:0]            b_resp_q;

    logic [7:0]            r_cnt_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [USER_WIDTH-1:0] r_user_q;
    logic [1:0]            r_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic                  req_push, req_pop, req_full, req_empty;
    logic [MSG_W-1:0]      req_head;
    logic                  resp_push, resp_pop, resp_full, resp_empty;
    logic [MSG_W-1:0]      resp_head;

    // Bits above the message fields carry no meaning on writes.
    logic unused_w_data;
    assign unused_w_data = ^w_data[DATA_WIDTH-1:MSG_W];

    host_msg_fifo #(.WIDTH(MSG_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (req_push),
        .push_data (w_data[MSG_W-1:0]),
        .pop       (req_pop),
        .head      (req_head),
        .full      (req_full),
        .empty     (req_empty)
    );

    host_msg_fifo #(.WIDTH(MSG_W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (resp_push),
        .push_data ({resp_id, resp_data}),
        .pop       (resp_pop),
        .head      (resp_head),
        .full      (resp_full),
        .empty     (resp_empty)
    );

    assign req_valid  = !req_empty;
    assign req_id     = req_head[MSG_W-1:MSG_DATA_WIDTH];
    assign req_data   = req_head[MSG_DATA_WIDTH-1:0];
    assign req_pop    = req_valid && req_ready;
    assign resp_ready = !resp_full;
    assign resp_push  = resp_valid && !resp_full;

    assign b_id   = w_id_q;
    assign b_user = w_user_q;
    assign b_resp = b_resp_q;
    assign r_id   = r_id_q;
    assign r_user = r_user_q;
    assign r_resp = r_resp_q;
    assign r_data = r_data_q;

    // State registers for both channel FSMs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
        end
    end

    // Write FSM: single beats become messages, bursts are swallowed and flagged.
    always_comb begin
        w_state_nx = w_state;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        req_push   = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (aw_valid) w_state_nx = W_DATA;
            end
            W_DATA: begin
                if (w_single_q) begin
                    w_ready = !req_full;
                    if (w_valid && !req_full) begin
                        req_push   = 1'b1;
                        w_state_nx = W_RESP;
                    end
                end else begin
                    w_ready = 1'b1;
                    if (w_valid && w_last) w_state_nx = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (b_ready) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // Write-side context: transaction attributes and the response code.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_single_q <= 1'b0;
            w_id_q     <= '0;
            w_user_q   <= '0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            if (aw_valid && aw_ready) begin
                w_single_q <= (aw_len == 8'd0);
                w_id_q     <= aw_id;
                w_user_q   <= aw_user;
            end
            if (w_state == W_DATA && w_state_nx == W_RESP)
                b_resp_q <= w_single_q ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read FSM: single reads poll the response FIFO, bursts return error beats.
    always_comb begin
        r_state_nx = r_state;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        r_last     = 1'b0;
        resp_pop   = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) begin
                    r_state_nx = R_DATA;
                    resp_pop   = (ar_len == 8'd0) && !resp_empty;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                r_last  = (r_cnt_q == 8'd0);
                if (r_ready && r_cnt_q == 8'd0) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Read-side context: captured message, response code and remaining beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt_q  <= '0;
            r_id_q   <= '0;
            r_user_q <= '0;
            r_resp_q <= RESP_OKAY;
            r_data_q <= '0;
        end else if (ar_valid && ar_ready) begin
            r_cnt_q  <= ar_len;
            r_id_q   <= ar_id;
            r_user_q <= ar_user;
            r_resp_q <= (ar_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
            r_data_q <= resp_pop ? (DATA_WIDTH'(resp_head) | (DATA_WIDTH'(1) << (DATA_WIDTH - 1)))
                                 : '0;
        end else if (r_state == R_DATA && r_ready && r_cnt_q != 8'd0) begin
            r_cnt_q <= r_cnt_q - 8'd1;
        end
    end
endmodule

// File: tb/tb_host_msg_bridge.sv
// tb_host_msg_bridge: randomized bench against a queue-based message model of the bridge.
`timescale 1ns/1ps
module tb_host_msg_bridge;
    localparam int unsigned ID_W   = 1;
    localparam int unsigned USER_W = 1;
    localparam int unsigned DW     = 64;
    localparam int unsigned MIW    = 16;
    localparam int unsigned MDW    = 16;
    localparam int unsigned MW     = MIW + MDW;
    localparam int unsigned REQ_D  = 4;
    localparam int unsigned RESP_D = 4;
    localparam int          BOUND  = 300;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              aw_valid = 1'b0, aw_ready;
    logic [ID_W-1:0]   aw_id = '0;
    logic [7:0]        aw_len = '0;
    logic [USER_W-1:0] aw_user = '0;
    logic              w_valid = 1'b0, w_ready;
    logic [DW-1:0]     w_data = '0;
    logic              w_last = 1'b0;
    logic              b_valid, b_ready = 1'b0;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    logic [USER_W-1:0] b_user;
    logic              ar_valid = 1'b0, ar_ready;
    logic [ID_W-1:0]   ar_id = '0;
    logic [7:0]        ar_len = '0;
    logic [USER_W-1:0] ar_user = '0;
    logic              r_valid, r_ready = 1'b0;
    logic [ID_W-1:0]   r_id;
    logic [DW-1:0]     r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic [USER_W-1:0] r_user;
    logic              req_valid, req_ready = 1'b0;
    logic [MIW-1:0]    req_id;
    logic [MDW-1:0]    req_data;
    logic              resp_valid = 1'b0, resp_ready;
    logic [MIW-1:0]    resp_id = '0;
    logic [MDW-1:0]    resp_data = '0;

    host_msg_bridge #(
        .ID_WIDTH(ID_W), .USER_WIDTH(USER_W), .DATA_WIDTH(DW),
        .MSG_ID_WIDTH(MIW), .MSG_DATA_WIDTH(MDW),
        .REQ_DEPTH(REQ_D), .RESP_DEPTH(RESP_D)
    ) dut (
        .clk(clk), .rstn(rstn),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_len(aw_len), .aw_user(aw_user),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_len(ar_len), .ar_user(ar_user),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_user(r_user),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: messages in flight toward the host and toward the CPU.
    logic [MW-1:0] req_q[$];
    logic [MW-1:0] resp_q[$];
    logic [MW-1:0] host_script[$];

    int req_mode   = 0;   // 0: only explicit pulses, 1: random ready, 2: always ready
    int pulse_req  = 0;
    int pulse_done = 0;
    int resp_mode  = 0;   // 0: scripted messages only, 1: plus random traffic
    bit resp_pend  = 1'b0;
    bit pend_script = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Host request side: drives req_ready just after the edge and checks each delivered message.
    always @(posedge clk) begin
        #1;
        req_ready = 1'b0;
        if (rstn) begin
            case (req_mode)
                1:       req_ready = ($urandom_range(0, 1) == 1);
                2:       req_ready = 1'b1;
                default: if (pulse_done < pulse_req && req_valid) begin
                             req_ready = 1'b1;
                             pulse_done++;
                         end
            endcase
            if (req_valid && req_ready) begin
                if (req_q.size() == 0) check_eq("req_unexpected", 64'(req_valid), 64'd0);
                else check_eq("req_msg", 64'({req_id, req_data}), 64'(req_q.pop_front()));
            end
        end
    end

    // Host response side: records accepted messages after the edge, then presents the next one.
    always @(posedge clk) begin
        #1;
        if (resp_pend && rstn) begin
            resp_q.push_back({resp_id, resp_data});
            if (pend_script) host_script.delete(0);
        end
        resp_valid  = 1'b0;
        pend_script = 1'b0;
        if (rstn) begin
            if (host_script.size() != 0) begin
                resp_valid = 1'b1;
                {resp_id, resp_data} = host_script[0];
                pend_script = 1'b1;
            end else if (resp_mode == 1 && $urandom_range(0, 2) == 0) begin
                resp_valid = 1'b1;
                {resp_id, resp_data} = MW'($urandom);
            end
        end
        resp_pend = resp_valid && resp_ready;
    end

    task automatic cpu_write(input logic [ID_W-1:0] id, input logic [USER_W-1:0] user,
                             input logic [7:0] len, input logic [DW-1:0] data, output int lat);
        int t;
        int t0;
        aw_valid = 1'b1; aw_id = id; aw_user = user; aw_len = len;
        w_valid = 1'b1; w_data = data; w_last = (len == 8'd0);
        t = 0;
        while (!aw_ready && t < BOUND) begin @(negedge clk); t++; end
        check_eq("aw_accept", 64'(aw_ready), 64'd1);
        t0 = cyc;
        @(negedge clk);
        aw_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b != 0) w_data = DW'({$urandom, $urandom});
            w_last = (b == int'(len));
            t = 0;
            while (!w_ready && t < BOUND) begin @(negedge clk); t++; end
            check_eq("w_accept", 64'(w_ready), 64'd1);
            if (len == 8'd0) req_q.push_back(data[MW-1:0]);
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        t = 0;
        while (!b_valid && t < BOUND) begin @(negedge clk); t++; end
        lat = cyc - t0;
        check_eq("b_valid", 64'(b_valid), 64'd1);
        check_eq("b_resp", 64'(b_resp), (len == 8'd0) ? 64'd0 : 64'd2);
        check_eq("b_id", 64'(b_id), 64'(id));
        check_eq("b_user", 64'(b_user), 64'(user));
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic cpu_read(input logic [ID_W-1:0] id, input logic [USER_W-1:0] user,
                            input logic [7:0] len);
        int t;
        logic [DW-1:0] exp_data;
        ar_valid = 1'b1; ar_id = id; ar_user = user; ar_len = len;
        t = 0;
        while (!ar_ready && t < BOUND) begin @(negedge clk); t++; end
        check_eq("ar_accept", 64'(ar_ready), 64'd1);
        exp_data = '0;
        if (len == 8'd0 && resp_q.size() != 0)
            exp_data = (DW'(1) << (DW - 1)) | DW'(resp_q.pop_front());
        @(negedge clk);
        ar_valid = 1'b0;
        check_eq("r_valid_lat", 64'(r_valid), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            r_ready = ($urandom_range(0, 3) != 0);
            while (!(r_valid && r_ready) && t < BOUND) begin
                @(negedge clk);
                r_ready = ($urandom_range(0, 3) != 0);
                t++;
            end
            check_eq("r_valid", 64'(r_valid), 64'd1);
            check_eq("r_data", r_data, exp_data);
            check_eq("r_resp", 64'(r_resp), (len == 8'd0) ? 64'd0 : 64'd2);
            check_eq("r_last", 64'(r_last), 64'(b == int'(len)));
            check_eq("r_id", 64'(r_id), 64'(id));
            check_eq("r_user", 64'(r_user), 64'(user));
            @(negedge clk);
            r_ready = 1'b0;
        end
        check_eq("r_idle", 64'(ar_ready), 64'd1);
    endtask

    task automatic wait_resp_count(input int n);
        int t;
        t = 0;
        while (resp_q.size() != n && t < BOUND) begin @(negedge clk); t++; end
        check_eq("resp_fill", 64'(resp_q.size()), 64'(n));
    endtask

    initial begin
        int lat;
        int t;
        repeat (3) @(negedge clk);
        check_eq("rst_aw_ready", 64'(aw_ready), 64'd1);
        check_eq("rst_ar_ready", 64'(ar_ready), 64'd1);
        check_eq("rst_w_ready", 64'(w_ready), 64'd0);
        check_eq("rst_b_valid", 64'(b_valid), 64'd0);
        check_eq("rst_r_valid", 64'(r_valid), 64'd0);
        check_eq("rst_req_valid", 64'(req_valid), 64'd0);
        check_eq("rst_resp_ready", 64'(resp_ready), 64'd1);
        check_eq("rst_b_resp", 64'(b_resp), 64'd0);
        check_eq("rst_r_resp", 64'(r_resp), 64'd0);
        check_eq("rst_r_last", 64'(r_last), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single write, minimum latency, message visible to the host.
        cpu_write(1'b1, 1'b0, 8'd0, 64'h0000_0000_0012_ABCD, lat);
        check_eq("wr_latency", 64'(lat), 64'd2);
        check_eq("req_valid_1", 64'(req_valid), 64'd1);
        check_eq("req_id_1", 64'(req_id), 64'h0012);
        check_eq("req_data_1", 64'(req_data), 64'hABCD);
        pulse_req++;
        repeat (2) @(negedge clk);
        check_eq("req_popped", 64'(req_valid), 64'd0);

        // Fill the request FIFO, then a fifth write must stall until one message leaves.
        for (int i = 0; i < int'(REQ_D); i++)
            cpu_write(ID_W'(i), USER_W'(i), 8'd0, DW'({$urandom, $urandom}), lat);
        check_eq("req_full_valid", 64'(req_valid), 64'd1);
        fork
            cpu_write(1'b0, 1'b1, 8'd0, DW'({$urandom, $urandom}), lat);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check_eq("blk_w_ready", 64'(w_ready), 64'd0);
                    check_eq("blk_b_valid", 64'(b_valid), 64'd0);
                end
                pulse_req++;
            end
        join
        req_mode = 2;
        t = 0;
        while (req_q.size() != 0 && t < BOUND) begin @(negedge clk); t++; end
        check_eq("req_drain", 64'(req_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        req_mode = 0;
        @(negedge clk);
        check_eq("req_empty", 64'(req_valid), 64'd0);

        // One host response, read once with the message, then again with nothing.
        host_script.push_back(32'h0003_5555);
        wait_resp_count(1);
        cpu_read(1'b1, 1'b1, 8'd0);
        cpu_read(1'b0, 1'b0, 8'd0);
        check_eq("resp_not_full", 64'(resp_ready), 64'd1);

        // Bursts: write discarded with SLVERR, read returns zero beats and leaves the FIFO alone.
        cpu_write(1'b1, 1'b1, 8'd3, DW'({$urandom, $urandom}), lat);
        check_eq("burst_no_req", 64'(req_valid), 64'd0);
        host_script.push_back(32'hBEEF_0042);
        wait_resp_count(1);
        cpu_read(1'b1, 1'b0, 8'd1);
        cpu_read(1'b0, 1'b1, 8'd0);

        // Full response FIFO with the host still pushing; reads free slots that refill in order.
        for (int i = 0; i < int'(RESP_D) + 2; i++) host_script.push_back(MW'($urandom));
        wait_resp_count(int'(RESP_D));
        check_eq("resp_full", 64'(resp_ready), 64'd0);
        cpu_read(1'b0, 1'b0, 8'd0);
        wait_resp_count(int'(RESP_D));
        check_eq("resp_refull", 64'(resp_ready), 64'd0);
        cpu_read(1'b1, 1'b0, 8'd0);
        wait_resp_count(int'(RESP_D));
        for (int i = 0; i < int'(RESP_D) + 1; i++) cpu_read(ID_W'(i), USER_W'(i), 8'd0);
        check_eq("resp_drained", 64'(resp_ready), 64'd1);

        // Reset in the middle of a write and a read with messages queued.
        cpu_write(1'b0, 1'b0, 8'd0, DW'({$urandom, $urandom}), lat);
        cpu_write(1'b1, 1'b0, 8'd0, DW'({$urandom, $urandom}), lat);
        host_script.push_back(MW'($urandom));
        wait_resp_count(1);
        aw_valid = 1'b1; aw_len = 8'd0; w_valid = 1'b0;
        ar_valid = 1'b1; ar_len = 8'd0; r_ready = 1'b0;
        @(negedge clk);
        aw_valid = 1'b0; ar_valid = 1'b0;
        check_eq("pre_rst_w_ready", 64'(w_ready), 64'd1);
        check_eq("pre_rst_r_valid", 64'(r_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_b_valid", 64'(b_valid), 64'd0);
        check_eq("mid_rst_r_valid", 64'(r_valid), 64'd0);
        check_eq("mid_rst_w_ready", 64'(w_ready), 64'd0);
        check_eq("mid_rst_req_valid", 64'(req_valid), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        req_q.delete();
        resp_q.delete();
        @(negedge clk);
        check_eq("post_rst_aw_ready", 64'(aw_ready), 64'd1);
        check_eq("post_rst_ar_ready", 64'(ar_ready), 64'd1);
        check_eq("post_rst_req_valid", 64'(req_valid), 64'd0);
        check_eq("post_rst_resp_ready", 64'(resp_ready), 64'd1);

        // Random concurrent traffic on both channels and both host ports.
        req_mode  = 1;
        resp_mode = 1;
        for (int i = 0; i < 80; i++) begin
            logic [ID_W-1:0]   wid, rid;
            logic [USER_W-1:0] wu, ru;
            logic [7:0]        wl, rl;
            logic [DW-1:0]     wd;
            int                wlat;
            wid = ID_W'($urandom); rid = ID_W'($urandom);
            wu = USER_W'($urandom); ru = USER_W'($urandom);
            wl = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            rl = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
            wd = DW'({$urandom, $urandom});
            fork
                cpu_write(wid, wu, wl, wd, wlat);
                cpu_read(rid, ru, rl);
            join
        end

        resp_mode = 0;
        req_mode  = 2;
        t = 0;
        while (req_q.size() != 0 && t < BOUND) begin @(negedge clk); t++; end
        check_eq("final_req_drain", 64'(req_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("final_req_empty", 64'(req_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
